// File: rtl/debug_packetiser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debug_packetiser_pkg
//  Purpose  : Shared radar debug-path types and constants. Holds the PACKET
//             beat format that the streamer consumes, the live-buffer depth
//             both blocks size against, and the packetiser state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package debug_packetiser_pkg;

    // Depth of the live debug buffer, shared with the streamer.
    localparam int DEBUG_BUFFER_DEPTH = 8192;

    // Width of the sample field carried in one PACKET beat.
    localparam int PKT_DATA_WIDTH = 14;

    // One beat on the packet bus between packetiser and streamer.
    typedef struct packed {
        logic                      Valid;
        logic                      SoP;
        logic                      EoP;
        logic [PKT_DATA_WIDTH-1:0] Data;
    } PACKET;

    // Packetiser control states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_CAPTURING = 2'd2,
        ST_HOLDOFF   = 2'd3
    } pktiser_state_t;

endpackage
`default_nettype wire

// File: rtl/debug_packetiser_if.sv
`default_nettype none
// ============================================================================
//  Module   : debug_packetiser_if
//  Purpose  : Sample-in / packet-out bus of the debug packetiser.
//  Signals  : ipData   - sample data from the ADC / DSP tap
//             ipValid  - ipData qualifier
//             opPacket - framed beat towards the debug streamer
//  Modports : master - sample source / packet sink
//             slave  - the packetiser itself
//  Revision : 1.0  initial release
// ============================================================================
interface debug_packetiser_if #(
    parameter int DATA_WIDTH = 14
);
    import debug_packetiser_pkg::*;

    logic [DATA_WIDTH-1:0] ipData;
    logic                  ipValid;
    PACKET                 opPacket;

    modport master (
        output ipData,
        output ipValid,
        input  opPacket
    );

    modport slave (
        input  ipData,
        input  ipValid,
        output opPacket
    );

endinterface
`default_nettype wire

// File: rtl/debug_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : debug_decimator
//  Purpose  : Keep-1-of-N strobe generator for debug taps. The ratio is
//             latched on i_load (0 is treated as 1) and the phase counter is
//             cleared at the same time, so the first valid sample after a
//             load is always kept.
//  Ports    : clk, rst     - clock, synchronous active-high reset
//             i_load       - latch i_decimate and clear the phase counter
//             i_active     - counter advances only while active
//             i_valid      - input sample qualifier
//             i_decimate   - keep 1 of every N valid samples
//             o_keep       - current sample is to be kept (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module debug_decimator #(
    parameter int DEC_WIDTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_load,
    input  wire logic                 i_active,
    input  wire logic                 i_valid,
    input  wire logic [DEC_WIDTH-1:0] i_decimate,
    output logic                      o_keep
);

    localparam logic [DEC_WIDTH-1:0] c_ONE = DEC_WIDTH'(1);

    logic [DEC_WIDTH-1:0] r_dec;
    logic [DEC_WIDTH-1:0] r_dec_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec     <= c_ONE;
            r_dec_cnt <= '0;
        end else if (i_load) begin
            r_dec     <= (i_decimate == '0) ? c_ONE : i_decimate;
            r_dec_cnt <= '0;
        end else if (i_active && i_valid) begin
            // Cycles without a valid sample leave the phase untouched.
            if (r_dec_cnt == (r_dec - c_ONE))
                r_dec_cnt <= '0;
            else
                r_dec_cnt <= r_dec_cnt + c_ONE;
        end
    end

    assign o_keep = i_active && i_valid && (r_dec_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/debug_packetiser.sv
`default_nettype none
// ============================================================================
//  Module   : debug_packetiser
//  Purpose  : Frames a fixed number of (optionally decimated) radar samples
//             into one SoP..EoP packet on the rising edge of a trigger, and
//             feeds it straight into the debug streamer.
//  Ports    : ipClk      - system clock
//             ipReset    - synchronous active-high reset (registered once)
//             bus        - ipData/ipValid in, opPacket out (slave modport)
//             ipTrigger  - capture trigger level; rising edge starts capture
//             ipEnable   - arms the packetiser
//             ipLength   - samples per packet, latched at trigger (0 -> 1)
//             ipDecimate - keep 1 of N valid samples, latched at trigger
//             opBusy     - high while Capturing or in Holdoff
//             opMissed   - saturating count of triggers ignored while busy
//  Revision : 1.0  initial release
// ============================================================================
module debug_packetiser
    import debug_packetiser_pkg::*;
#(
    parameter int DATA_WIDTH   = PKT_DATA_WIDTH,
    parameter int LENGTH_WIDTH = $clog2(DEBUG_BUFFER_DEPTH),
    parameter int HOLDOFF      = 16
) (
    input  wire logic                    ipClk,
    input  wire logic                    ipReset,
    debug_packetiser_if.slave            bus,
    input  wire logic                    ipTrigger,
    input  wire logic                    ipEnable,
    input  wire logic [LENGTH_WIDTH-1:0] ipLength,
    input  wire logic [7:0]              ipDecimate,
    output logic                         opBusy,
    output logic [7:0]                   opMissed
);

    localparam int                      c_HOLD_W   = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [c_HOLD_W-1:0]     c_HOLD_END = c_HOLD_W'(HOLDOFF - 1);
    localparam logic [LENGTH_WIDTH-1:0] c_LEN_ONE  = LENGTH_WIDTH'(1);

    logic                    r_reset;
    pktiser_state_t          r_state;
    logic                    r_trig_prev;
    logic [7:0]              r_missed;
    logic [LENGTH_WIDTH-1:0] r_length;
    logic [LENGTH_WIDTH-1:0] r_sample_cnt;
    logic [c_HOLD_W-1:0]     r_hold_cnt;
    PACKET                   r_pkt;
    logic [DATA_WIDTH-1:0]   w_sample;

    logic w_trig_edge;
    logic w_start;
    logic w_capturing;
    logic w_busy;
    logic w_keep;
    logic w_last;

    // The effective reset is deliberately one cycle behind ipReset; the
    // streamer sees the same registered reset, so both drop together.
    always_ff @(posedge ipClk) begin
        r_reset <= ipReset;
    end

    assign w_sample    = bus.ipData;
    assign w_trig_edge = ipTrigger && !r_trig_prev;
    assign w_capturing = (r_state == ST_CAPTURING);
    assign w_busy      = w_capturing || (r_state == ST_HOLDOFF);
    // The Armed -> Idle exit on a dropped enable takes priority over a trigger.
    assign w_start     = (r_state == ST_ARMED) && ipEnable && w_trig_edge;
    assign w_last      = (r_sample_cnt == (r_length - c_LEN_ONE));

    debug_decimator #(
        .DEC_WIDTH (8)
    ) u_decimator (
        .clk        (ipClk),
        .rst        (r_reset),
        .i_load     (w_start),
        .i_active   (w_capturing),
        .i_valid    (bus.ipValid),
        .i_decimate (ipDecimate),
        .o_keep     (w_keep)
    );

    always_ff @(posedge ipClk) begin
        if (r_reset) begin
            r_state      <= ST_IDLE;
            r_trig_prev  <= 1'b0;
            r_missed     <= '0;
            r_length     <= c_LEN_ONE;
            r_sample_cnt <= '0;
            r_hold_cnt   <= '0;
            r_pkt.Valid  <= 1'b0;
            r_pkt.SoP    <= 1'b0;
            r_pkt.EoP    <= 1'b0;
        end else begin
            r_trig_prev <= ipTrigger;

            // Beat flags default low; SoP/EoP only ever accompany Valid.
            r_pkt.Valid <= 1'b0;
            r_pkt.SoP   <= 1'b0;
            r_pkt.EoP   <= 1'b0;

            if (w_trig_edge && w_busy && (r_missed != 8'hFF))
                r_missed <= r_missed + 8'd1;

            case (r_state)
                ST_IDLE: begin
                    if (ipEnable)
                        r_state <= ST_ARMED;
                end

                ST_ARMED: begin
                    if (!ipEnable) begin
                        r_state <= ST_IDLE;
                    end else if (w_trig_edge) begin
                        r_state      <= ST_CAPTURING;
                        r_length     <= (ipLength == '0) ? c_LEN_ONE : ipLength;
                        r_sample_cnt <= '0;
                    end
                end

                ST_CAPTURING: begin
                    // ipEnable is ignored here: the packet always runs to EoP
                    // so the streamer is never left waiting mid-packet.
                    if (w_keep) begin
                        r_pkt.Valid  <= 1'b1;
                        r_pkt.Data   <= w_sample;
                        r_pkt.SoP    <= (r_sample_cnt == '0);
                        r_pkt.EoP    <= w_last;
                        r_sample_cnt <= r_sample_cnt + c_LEN_ONE;
                        if (w_last) begin
                            r_state    <= ST_HOLDOFF;
                            r_hold_cnt <= '0;
                        end
                    end
                end

                ST_HOLDOFF: begin
                    if (r_hold_cnt == c_HOLD_END)
                        r_state <= ipEnable ? ST_ARMED : ST_IDLE;
                    else
                        r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.opPacket = r_pkt;
    assign opBusy       = w_busy;
    assign opMissed     = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_debug_packetiser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debug_packetiser
//  Purpose  : Directed self-checking bench for debug_packetiser.
//             Inputs change 1 time unit after the rising edge and outputs are
//             sampled at the same point, so each tick() shows the registers
//             updated by the edge just taken.
//  Revision : 1.0  initial release
// ============================================================================
module tb_debug_packetiser;
    import debug_packetiser_pkg::*;

    logic        ipClk = 1'b0;
    logic        ipReset;
    logic        ipTrigger;
    logic        ipEnable;
    logic [12:0] ipLength;
    logic [7:0]  ipDecimate;
    logic        opBusy;
    logic [7:0]  opMissed;

    debug_packetiser_if u_bus ();

    debug_packetiser dut (
        .ipClk      (ipClk),
        .ipReset    (ipReset),
        .bus        (u_bus),
        .ipTrigger  (ipTrigger),
        .ipEnable   (ipEnable),
        .ipLength   (ipLength),
        .ipDecimate (ipDecimate),
        .opBusy     (opBusy),
        .opMissed   (opMissed)
    );

    always #5 ipClk = ~ipClk;

    int          n_vec = 0;
    int          n_err = 0;
    int          ramp  = 0;
    logic [13:0] bq_data[$];
    bit          bq_sop[$];
    bit          bq_eop[$];

    task automatic tick();
        @(posedge ipClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Single-cycle trigger pulse: rising edge seen on the next clock.
    task automatic fire();
        ipTrigger = 1'b1;
        tick();
        ipTrigger = 1'b0;
    endtask

    // Drive a data ramp and record beats until EoP or the cycle budget runs out.
    task automatic collect(input string tag, input int max_cyc,
                           input int drop_en_after, input bit toggle_valid);
        bit   done = 1'b0;
        int   cyc  = 0;
        logic v;
        bq_data.delete();
        bq_sop.delete();
        bq_eop.delete();
        ipTrigger = 1'b0;
        while (!done && cyc < max_cyc) begin
            v             = toggle_valid ? ((cyc % 2) == 0) : 1'b1;
            u_bus.ipValid = v;
            u_bus.ipData  = 14'(ramp);
            ramp++;
            tick();
            cyc++;
            if (u_bus.opPacket.Valid) begin
                chk({tag, "_vin"}, 32'(v), 32'd1);
                bq_data.push_back(u_bus.opPacket.Data);
                bq_sop.push_back(u_bus.opPacket.SoP);
                bq_eop.push_back(u_bus.opPacket.EoP);
                if (drop_en_after > 0 && bq_data.size() == drop_en_after)
                    ipEnable = 1'b0;
                if (u_bus.opPacket.EoP)
                    done = 1'b1;
            end else begin
                chk({tag, "_flags_idle"}, {30'd0, u_bus.opPacket.SoP, u_bus.opPacket.EoP}, 32'd0);
            end
        end
        chk({tag, "_eop_seen"}, 32'(done), 32'd1);
    endtask

    task automatic expect_beats(input string tag, input int n, input int base, input int step);
        chk({tag, "_nbeats"}, 32'(bq_data.size()), 32'(n));
        for (int i = 0; i < n && i < bq_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 32'(bq_data[i]), 32'(base + i * step));
            chk($sformatf("%s_sop%0d", tag, i), 32'(bq_sop[i]), 32'(i == 0));
            chk($sformatf("%s_eop%0d", tag, i), 32'(bq_eop[i]), 32'(i == n - 1));
        end
    endtask

    // Holdoff spans 16 clocks after the EoP edge: busy at +15, clear at +16.
    task automatic wait_holdoff(input string tag);
        repeat (15) tick();
        chk({tag, "_busy_holdoff"}, 32'(opBusy), 32'd1);
        tick();
        chk({tag, "_busy_after"}, 32'(opBusy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;

        ipReset       = 1'b1;
        ipTrigger     = 1'b0;
        ipEnable      = 1'b0;
        ipLength      = 13'd4;
        ipDecimate    = 8'd1;
        u_bus.ipValid = 1'b0;
        u_bus.ipData  = '0;

        // Reset
        repeat (3) tick();
        ipReset = 1'b0;
        repeat (2) tick();
        chk("rst_valid", 32'(u_bus.opPacket.Valid), 32'd0);
        chk("rst_sop", 32'(u_bus.opPacket.SoP), 32'd0);
        chk("rst_eop", 32'(u_bus.opPacket.EoP), 32'd0);
        chk("rst_busy", 32'(opBusy), 32'd0);
        chk("rst_missed", 32'(opMissed), 32'd0);

        // 1: length 4, no decimation; first Capturing-cycle sample is 105
        ipEnable      = 1'b1;
        u_bus.ipValid = 1'b1;
        repeat (2) tick();
        u_bus.ipData = 14'd104;
        fire();
        chk("t1_busy_start", 32'(opBusy), 32'd1);
        ramp = 105;
        collect("t1", 20, 0, 1'b0);
        expect_beats("t1", 4, 105, 1);
        wait_holdoff("t1");

        // 2: length 3, decimate by 4 -> 0, 4, 8
        ipLength   = 13'd3;
        ipDecimate = 8'd4;
        fire();
        ramp = 0;
        collect("t2", 30, 0, 1'b0);
        expect_beats("t2", 3, 0, 4);
        wait_holdoff("t2");

        // 3: ipValid toggling, length 2 -> 200, 202
        ipLength   = 13'd2;
        ipDecimate = 8'd1;
        fire();
        ramp = 200;
        collect("t3", 20, 0, 1'b1);
        expect_beats("t3", 2, 200, 2);
        wait_holdoff("t3");

        // 4: length 0 -> single SoP+EoP beat, then missed-trigger counting
        ipLength      = 13'd0;
        u_bus.ipValid = 1'b1;
        fire();
        ramp = 300;
        collect("t4", 10, 0, 1'b0);
        expect_beats("t4", 1, 300, 1);
        repeat (3) begin
            ipTrigger = 1'b1;
            tick();
            ipTrigger = 1'b0;
            tick();
        end
        chk("t4_missed3", 32'(opMissed), 32'd3);
        repeat (10) tick();
        chk("t4_busy_after", 32'(opBusy), 32'd0);

        // Hold Capturing open with no valid samples while 300 edges arrive.
        ipLength      = 13'd1;
        u_bus.ipValid = 1'b0;
        fire();
        tick();
        repeat (300) begin
            ipTrigger = 1'b1;
            tick();
            ipTrigger = 1'b0;
            tick();
        end
        chk("t4_missed_sat", 32'(opMissed), 32'd255);
        chk("t4_busy_capt", 32'(opBusy), 32'd1);
        chk("t4_no_beat", 32'(u_bus.opPacket.Valid), 32'd0);
        ramp = 600;
        collect("t4b", 10, 0, 1'b0);
        expect_beats("t4b", 1, 600, 1);
        wait_holdoff("t4b");

        // 5: enable dropped after 2 of 8 beats; packet still completes
        ipLength = 13'd8;
        fire();
        ramp = 400;
        collect("t5", 30, 2, 1'b0);
        expect_beats("t5", 8, 400, 1);
        wait_holdoff("t5");
        fire();
        seen = 0;
        repeat (20) begin
            tick();
            if (u_bus.opPacket.Valid) seen++;
        end
        chk("t5_idle_nobeat", 32'(seen), 32'd0);
        chk("t5_idle_busy", 32'(opBusy), 32'd0);
        chk("t5_idle_missed", 32'(opMissed), 32'd255);

        // 6: reset during beat 5 of 8
        ipEnable = 1'b1;
        repeat (2) tick();
        ipLength      = 13'd8;
        u_bus.ipValid = 1'b1;
        u_bus.ipData  = 14'd499;
        fire();
        for (int i = 0; i < 5; i++) begin
            u_bus.ipData = 14'(500 + i);
            tick();
            chk($sformatf("t6_beat%0d_valid", i), 32'(u_bus.opPacket.Valid), 32'd1);
            chk($sformatf("t6_beat%0d_data", i), 32'(u_bus.opPacket.Data), 32'(500 + i));
        end
        ipReset      = 1'b1;
        u_bus.ipData = 14'd505;
        tick();
        chk("t6_beat6_before_reset", 32'(u_bus.opPacket.Valid), 32'd1);
        ipReset      = 1'b0;
        u_bus.ipData = 14'd506;
        tick();
        chk("t6_rst_valid", 32'(u_bus.opPacket.Valid), 32'd0);
        chk("t6_rst_eop", 32'(u_bus.opPacket.EoP), 32'd0);
        chk("t6_rst_busy", 32'(opBusy), 32'd0);
        chk("t6_rst_missed", 32'(opMissed), 32'd0);
        repeat (2) tick();
        ipLength = 13'd2;
        fire();
        ramp = 700;
        collect("t6b", 10, 0, 1'b0);
        expect_beats("t6b", 2, 700, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debug_packetiser.md
Name: debug_packetiser

Overview:
- Upstream neighbour of the debug streamer.
- Takes a continuous 14-bit radar sample stream (ADC or DSP tap) and, on a trigger, frames a fixed number of optionally decimated samples into one PACKET with SoP and EoP.
- Its output drives the streamer's packet input directly, so every packet the ARM sees in the live buffer is produced here.

Parameters:
- DATA_WIDTH, 14, sample width; must match PACKET.Data.
- LENGTH_WIDTH, 13, width of the packet-length input; matches the 8192-word live buffer.
- HOLDOFF, 16, minimum idle clocks after EoP before re-arming.

Ports:
- ipClk  input  1  system clock; single clock domain.
- ipReset  input  1  synchronous, active-high reset.
- ipData  input  DATA_WIDTH  sample data.
- ipValid  input  1  ipData qualifier; may be high every cycle.
- ipTrigger  input  1  capture trigger (e.g. pulse start); level, rising edge used.
- ipEnable  input  1  arms the packetiser when high.
- ipLength  input  LENGTH_WIDTH  samples per packet; latched at trigger.
- ipDecimate  input  8  keep 1 of every N valid samples; latched at trigger.
- opPacket  output  PACKET  {Valid, SoP, EoP, Data}; registered.
- opBusy  output  1  high in Capturing and Holdoff.
- opMissed  output  8  saturating count of triggers ignored while busy.

Behaviour:
- Reset handling:
  - ipReset is registered once internally, so the effective reset is one cycle late.
  - Effective reset gives: opPacket.Valid/SoP/EoP = 0, opPacket.Data = X, opBusy = 0, opMissed = 0, state = Idle, previous-trigger register = 0.
- Trigger edge: TrigEdge = ipTrigger & ~TrigPrev, with TrigPrev registered every cycle.
- States:
  - Idle: outputs quiet. Go to Armed when ipEnable = 1.
  - Armed:
    - ipEnable = 0 → Idle.
    - TrigEdge → Capturing. On this transition:
      - latch Length = (ipLength == 0) ? 1 : ipLength;
      - latch Dec = (ipDecimate == 0) ? 1 : ipDecimate;
      - clear DecCount and SampleCount.
  - Capturing:
    - On each ipValid, a sample is kept when DecCount == 0.
    - DecCount increments and wraps at Dec-1. Cycles without ipValid do not advance it.
    - Kept sample: next cycle opPacket.Valid = 1, Data = ipData.
      - SoP = (SampleCount == 0).
      - EoP = (SampleCount == Length-1).
      - SampleCount then increments.
    - Otherwise opPacket.Valid = 0; SoP and EoP are only ever high together with Valid.
    - After the EoP beat → Holdoff.
    - Length = 1 gives a single beat with SoP and EoP both set.
  - Holdoff: count HOLDOFF cycles, then go to Armed if ipEnable, else Idle.
- Latency: sample accepted in cycle n appears on opPacket in cycle n+1.
- Data passes through unmodified; the streamer appends the 2 LSBs.
- ipEnable deasserted mid-capture: the packet always completes through EoP, because the streamer only returns to Idle on EoP.
- TrigEdge while in Capturing or Holdoff: ignored; opMissed increments and saturates at 255.
- TrigEdge in Idle: ignored, not counted.
- TrigEdge on the same cycle the state enters Armed: not seen, since the edge must occur while already in Armed.
- Effective reset mid-packet:
  - Valid drops the next cycle; no EoP is emitted.
  - The streamer shares the reset, so no truncated packet is left pending downstream.
- Counter widths:
  - SampleCount is LENGTH_WIDTH bits; full-scale length 8191 is supported.
  - DecCount is 8 bits.
- No backpressure: the streamer always accepts.

Decomposition:
- The PACKET struct (Valid, SoP, EoP, Data[13:0]) already lives in the shared radar package and is reused unchanged.
- Add to the shared package:
  - a packetiser state enum;
  - the DEBUG_BUFFER_DEPTH = 8192 constant, shared with the streamer.
- One natural sub-module: debug_decimator.
  - Contents: DecCount, Dec latch and keep strobe.
  - Reused for other debug taps.
- Everything else stays inline.

Test Plan:
1. Enable = 1, Length = 4, Decimate = 1, ipValid constant, data ramp 100,101,…; trigger edge at t0 when ramp = 105 → four beats with Data 105..108. SoP on 105, EoP on 108 only. opBusy = 1 through Holdoff, then 0.
2. Length = 3, Decimate = 4, ipValid every cycle, ramp from 0 at trigger → Data 0, 4, 8; EoP on 8.
3. ipValid toggling 1010…, Length = 2, Decimate = 1 → Valid beats only follow valid inputs; packet has exactly 2 beats; SoP/EoP never set on an invalid cycle.
4. Length = 0 → single beat with SoP = EoP = 1. Then three trigger edges during Capturing/Holdoff → opMissed = 3. Then 300 such edges → opMissed = 255.
5. Deassert ipEnable after 2 of 8 beats → all 8 beats emitted including EoP, then Idle; a later trigger produces no packet.
6. Assert ipReset during beat 5 of 8 → opPacket.Valid = 0 from the cycle after the registered reset; opMissed = 0, state = Idle. A new trigger after re-enable produces a fresh packet starting with SoP.
